// File: rtl/button_encoder_4x2_if.sv
// Purpose: bundles the raw button lines and the encoded press outputs.
// Latency: none, wiring only.
// Backpressure: none; outputs are levels/strobes with no ready path.
interface button_encoder_4x2_if;
  logic [3:0] i_btn_n;
  logic [1:0] o_code;
  logic       o_valid;
  logic       o_held;
  logic       o_multi;

  // Board/bench side: drives the buttons, observes the encoder.
  modport master (
    output i_btn_n,
    input  o_code,
    input  o_valid,
    input  o_held,
    input  o_multi
  );

  // Encoder side.
  modport slave (
    input  i_btn_n,
    output o_code,
    output o_valid,
    output o_held,
    output o_multi
  );
endinterface

// File: rtl/button_encoder_4x2.sv
// Purpose: sync + debounce four active-low buttons, encode a single press to a 2-bit index.
// Latency: DEBOUNCE_CYCLES+3 clocks from a stable input change to the registered outputs.
// Backpressure: none; o_valid is a one-cycle strobe that is not held for a consumer.
module button_encoder_4x2 #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  button_encoder_4x2_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_INVALID = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_cand;
  logic [3:0]       r_deb;
  logic [CNT_W-1:0] r_cnt;

  state_t           r_state;
  logic [1:0]       r_code;
  logic             r_valid;
  logic             r_held;
  logic             r_multi;

  logic             w_single;
  logic             w_released;
  logic [1:0]       w_idx;
  logic [3:0]       w_latched;

  // Two-flop synchroniser; buttons are asynchronous to i_clk.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= bus.i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: a new level must stay unchanged for DEBOUNCE_CYCLES cycles before it reaches deb.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cand <= 4'b1111;
      r_deb  <= 4'b1111;
      r_cnt  <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cand != r_deb) begin
      if (r_cnt == CNT_LAST) begin
        r_deb <= r_cand;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // Decode the debounced vector: inverse of the active-low 2-to-4 digit select.
  always_comb begin
    w_single   = 1'b0;
    w_idx      = 2'b00;
    w_released = (r_deb == 4'b1111);
    case (r_deb)
      4'b1110: begin w_single = 1'b1; w_idx = 2'b00; end
      4'b1101: begin w_single = 1'b1; w_idx = 2'b01; end
      4'b1011: begin w_single = 1'b1; w_idx = 2'b10; end
      4'b0111: begin w_single = 1'b1; w_idx = 2'b11; end
      default: begin w_single = 1'b0; w_idx = 2'b00; end
    endcase
  end

  // Active-low pattern of the button that was accepted; anything else while pressed is illegal.
  assign w_latched = ~(4'b0001 << r_code);

  // Press FSM with registered outputs; INVALID only exits through a full release.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_code  <= 2'b00;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            r_state <= S_PRESSED;
            r_code  <= w_idx;
            r_valid <= 1'b1;
            r_held  <= 1'b1;
          end else if (!w_released) begin
            r_state <= S_INVALID;
            r_multi <= 1'b1;
          end
        end
        S_PRESSED: begin
          if (w_released) begin
            r_state <= S_IDLE;
            r_held  <= 1'b0;
          end else if (r_deb != w_latched) begin
            r_state <= S_INVALID;
            r_held  <= 1'b0;
            r_multi <= 1'b1;
          end
        end
        S_INVALID: begin
          if (w_released) begin
            r_state <= S_IDLE;
            r_multi <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_held  <= 1'b0;
          r_multi <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_code  = r_code;
  assign bus.o_valid = r_valid;
  assign bus.o_held  = r_held;
  assign bus.o_multi = r_multi;

endmodule

// File: tb/tb_button_encoder_4x2.sv
// Purpose: directed bench for the debounced 4x2 button encoder (DEBOUNCE_CYCLES=4).
// Latency: outputs expected 7 edges after the first edge sampling a stable input.
// Backpressure: none; o_valid pulses are tallied one clock at a time.
module tb_button_encoder_4x2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   valid_cnt = 0;

  button_encoder_4x2_if bus ();

  button_encoder_4x2 #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Tally every o_valid pulse shortly after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (bus.o_valid === 1'b1) valid_cnt++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, bus.o_valid, 0);
    check({tag, "_held"},  bus.o_held,  0);
    check({tag, "_multi"}, bus.o_multi, 0);
    check({tag, "_code"},  bus.o_code,  0);
  endtask

  // Press a single button, release it, and check both latency boundaries.
  task automatic press_release(input logic [3:0] pat, input logic [1:0] code, input string tag);
    int v0;
    v0 = valid_cnt;
    bus.i_btn_n = pat;
    wait_n(7);
    check({tag, "_pre_valid"}, bus.o_valid, 0);
    check({tag, "_pre_held"},  bus.o_held,  0);
    wait_n(1);
    check({tag, "_valid"}, bus.o_valid, 1);
    check({tag, "_code"},  bus.o_code,  code);
    check({tag, "_held"},  bus.o_held,  1);
    check({tag, "_multi"}, bus.o_multi, 0);
    wait_n(1);
    check({tag, "_valid_pulse"}, bus.o_valid, 0);
    bus.i_btn_n = 4'b1111;
    wait_n(7);
    check({tag, "_rel_pre_held"}, bus.o_held, 1);
    wait_n(1);
    check({tag, "_rel_held"}, bus.o_held, 0);
    check({tag, "_rel_code"}, bus.o_code, code);
    wait_n(2);
    check({tag, "_valid_count"}, valid_cnt - v0, 1);
  endtask

  initial begin
    int v0;
    logic seen;
    bus.i_btn_n = 4'b1111;

    // Reset held: outputs cleared, pressed buttons ignored.
    rst = 1'b1;
    wait_n(3);
    check_idle("reset");
    bus.i_btn_n = 4'b0000;
    wait_n(4);
    check_idle("reset_btn");
    bus.i_btn_n = 4'b1111;
    wait_n(2);
    rst = 1'b0;
    wait_n(4);
    check_idle("post_reset");
    check("post_reset_pulses", valid_cnt, 0);

    // Single presses on every button.
    press_release(4'b1011, 2'b10, "p1011");
    press_release(4'b1110, 2'b00, "p1110");
    press_release(4'b1101, 2'b01, "p1101");
    press_release(4'b0111, 2'b11, "p0111");

    // Bounce: 2-cycle toggles never settle, then a stable 1101.
    v0 = valid_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.i_btn_n = (i % 2 == 0) ? 4'b1101 : 4'b1111;
      wait_n(2);
    end
    bus.i_btn_n = 4'b1101;
    wait_n(7);
    check("bounce_pre_valid", valid_cnt - v0, 0);
    wait_n(1);
    check("bounce_valid", bus.o_valid, 1);
    check("bounce_code",  bus.o_code,  2'b01);
    wait_n(2);
    check("bounce_count", valid_cnt - v0, 1);
    bus.i_btn_n = 4'b1111;
    wait_n(10);
    check("bounce_rel_held", bus.o_held, 0);

    // Glitch: 3-cycle 0111 pulse must be swallowed.
    v0 = valid_cnt;
    seen = 1'b0;
    bus.i_btn_n = 4'b0111;
    wait_n(3);
    bus.i_btn_n = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      wait_n(1);
      if (bus.o_held === 1'b1 || bus.o_multi === 1'b1) seen = 1'b1;
    end
    check("glitch_held_multi", seen, 0);
    check("glitch_valid", valid_cnt - v0, 0);

    // Multi press, change without release, release, then a clean press.
    v0 = valid_cnt;
    bus.i_btn_n = 4'b1100;
    wait_n(7);
    check("multi_pre", bus.o_multi, 0);
    wait_n(1);
    check("multi_set", bus.o_multi, 1);
    bus.i_btn_n = 4'b1101;
    wait_n(10);
    check("multi_stay", bus.o_multi, 1);
    check("multi_no_held", bus.o_held, 0);
    check("multi_no_valid", valid_cnt - v0, 0);
    bus.i_btn_n = 4'b1111;
    wait_n(7);
    check("multi_rel_pre", bus.o_multi, 1);
    wait_n(1);
    check("multi_rel", bus.o_multi, 0);
    wait_n(2);
    press_release(4'b1101, 2'b01, "after_multi");

    // Reset mid-press: outputs clear, held button re-fires after full latency.
    bus.i_btn_n = 4'b0111;
    wait_n(8);
    check("mid_valid", bus.o_valid, 1);
    check("mid_code", bus.o_code, 2'b11);
    wait_n(2);
    rst = 1'b1;
    wait_n(1);
    rst = 1'b0;
    check_idle("mid_reset");
    v0 = valid_cnt;
    wait_n(7);
    check("mid_pre_valid", valid_cnt - v0, 0);
    wait_n(1);
    check("mid_refire_valid", bus.o_valid, 1);
    check("mid_refire_code", bus.o_code, 2'b11);

    // Change without release while pressed: becomes invalid, code held.
    bus.i_btn_n = 4'b0011;
    wait_n(8);
    check("chg_multi", bus.o_multi, 1);
    check("chg_held", bus.o_held, 0);
    check("chg_code_hold", bus.o_code, 2'b11);
    bus.i_btn_n = 4'b1111;
    wait_n(8);
    check("chg_rel_multi", bus.o_multi, 0);
    check("chg_rel_valid", bus.o_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
